// File: rtl/lcd_fb_arbiter.sv
// Single-port 1bpp frame-buffer arbiter: LCD scanout prefetch FIFO has priority,
// a writer port takes the remaining memory cycles.
module lcd_fb_arbiter #(
    parameter int FB_WORDS   = 48000,
    parameter int AW         = 16,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_WATER  = 2
) (
    input  logic          PixelClk,
    input  logic          nRST,
    input  logic          frame_start,
    input  logic          pix_rd,
    output logic          pix_out,
    output logic          fifo_ready,
    output logic          underrun,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(MEM_LAT + FIFO_DEPTH + 2);
    localparam logic [CW:0]   LW_C      = (CW+1)'(LOW_WATER);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C    = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_WORDS - 1);

    typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE, GNT_DROP} gnt_t;

    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PW-1:0]      r_wptr, r_rptr;
    logic [CW-1:0]      r_count, r_inflight;
    logic [DW-1:0]      r_discard;
    logic [2:0]         r_bit_idx;
    logic [AW-1:0]      r_fetch_addr;
    logic [MEM_LAT:0]   r_rd_pipe;
    logic               r_fifo_ready, r_underrun;
    logic               r_mem_ce, r_mem_we, r_wr_ack;
    logic [AW-1:0]      r_mem_addr;
    logic [7:0]         r_mem_wdata;

    gnt_t               w_gnt;
    logic [CW:0]        w_credit;
    logic               w_ret, w_push, w_pop, w_empty;
    logic [7:0]         w_head;

    always_comb begin
        w_credit = {1'b0, r_count} + {1'b0, r_inflight};
        w_gnt    = GNT_IDLE;
        // Nothing is granted in the frame_start cycle; fetch restarts from 0 next cycle.
        if (!frame_start) begin
            if (w_credit < LW_C)
                w_gnt = GNT_READ;
            else if (wr_req && !r_wr_ack)
                w_gnt = (wr_addr > LAST_ADDR) ? GNT_DROP : GNT_WRITE;
            else if (w_credit < DEPTH_C)
                w_gnt = GNT_READ;
        end
    end

    always_comb begin
        w_ret   = r_rd_pipe[MEM_LAT];
        w_empty = (r_count == '0);
        w_head  = r_fifo[r_rptr];
        w_push  = w_ret && (r_discard == '0) && !frame_start;
        w_pop   = !frame_start && pix_rd && !w_empty && (r_bit_idx == 3'd7);
        pix_out = w_empty ? 1'b0 : w_head[3'd7 - r_bit_idx];
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_inflight   <= '0;
            r_discard    <= '0;
            r_bit_idx    <= '0;
            r_fetch_addr <= '0;
            r_rd_pipe    <= '0;
            r_fifo_ready <= 1'b0;
            r_underrun   <= 1'b0;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_ce  <= (w_gnt == GNT_READ) || (w_gnt == GNT_WRITE);
            r_mem_we  <= (w_gnt == GNT_WRITE);
            r_wr_ack  <= (w_gnt == GNT_WRITE) || (w_gnt == GNT_DROP);
            r_rd_pipe <= {r_rd_pipe[MEM_LAT-1:0], w_gnt == GNT_READ};
            if (w_gnt == GNT_READ)
                r_mem_addr <= r_fetch_addr;
            if (w_gnt == GNT_WRITE) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end

            if (frame_start) begin
                // Every read still outstanding (inflight or already discarding) is dropped on return.
                r_inflight   <= '0;
                r_discard    <= r_discard + DW'(r_inflight) - DW'(w_ret);
                r_fetch_addr <= '0;
                r_wptr       <= '0;
                r_rptr       <= '0;
                r_count      <= '0;
                r_bit_idx    <= '0;
                r_fifo_ready <= 1'b0;
                r_underrun   <= 1'b0;
            end else begin
                if (w_ret && (r_discard != '0))
                    r_discard <= r_discard - DW'(1);
                r_inflight <= r_inflight + CW'(w_gnt == GNT_READ) - CW'(w_ret && (r_discard == '0));
                if (w_gnt == GNT_READ)
                    r_fetch_addr <= (r_fetch_addr == LAST_ADDR) ? '0 : r_fetch_addr + AW'(1);

                if (w_push) begin
                    r_fifo[r_wptr] <= mem_rdata;
                    r_wptr         <= r_wptr + PW'(1);
                end
                if (w_pop)
                    r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);

                if (pix_rd) begin
                    if (w_empty)
                        r_underrun <= 1'b1;
                    else
                        r_bit_idx <= r_bit_idx + 3'd1;
                end
                if (r_count == FULL_C)
                    r_fifo_ready <= 1'b1;
            end
        end
    end

    assign fifo_ready = r_fifo_ready;
    assign underrun   = r_underrun;
    assign wr_ack     = r_wr_ack;
    assign mem_ce     = r_mem_ce;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Bench for lcd_fb_arbiter: behavioural RAM, pixel-stream model from word contents,
// writer scoreboard; frame size reduced so wrap fits in a short run.
module tb_lcd_fb_arbiter;

    localparam int AW  = 16;
    localparam int FBW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_rd = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [7:0]    mem_rdata = '0;
    logic [7:0]    rd_stage = '0;
    logic          pix_out, fifo_ready, underrun, wr_ack, mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    logic [7:0]    ram [65536];
    logic [7:0]    exp_mem [FBW];
    int            errors = 0;
    int            checks = 0;

    lcd_fb_arbiter #(
        .FB_WORDS(FBW), .AW(AW), .MEM_LAT(2), .FIFO_DEPTH(4), .LOW_WATER(2)
    ) dut (
        .PixelClk(clk), .nRST(rst_n), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_out(pix_out), .fifo_ready(fifo_ready), .underrun(underrun),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-output RAM: data for a read in cycle c is valid during cycle c+2.
    always @(posedge clk) begin
        if (mem_ce && mem_we) ram[mem_addr] <= mem_wdata;
        rd_stage  <= ram[mem_addr];
        mem_rdata <= rd_stage;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_pix(input int unsigned idx);
        logic [7:0] w;
        w = exp_mem[(idx / 8) % FBW];
        return w[7 - (idx % 8)];
    endfunction

    task automatic pulse_fs(input logic rd);
        frame_start = 1'b1;
        pix_rd      = rd;
        tick();
        frame_start = 1'b0;
        pix_rd      = 1'b0;
    endtask

    task automatic wait_ready(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (fifo_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic fill_random();
        for (int unsigned a = 0; a < FBW; a++) begin
            exp_mem[a] = 8'($urandom);
            ram[a]     = exp_mem[a];
        end
    endtask

    task automatic test_reset();
        bit ok;
        int unsigned got[$];
        int unsigned extra;
        repeat (3) tick();
        rst_n = 1'b1;
        pulse_fs(1'b0);
        wait_ready(30, ok);
        repeat (10) begin pix_rd = 1'b1; tick(); end
        pix_rd = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_ce, mem_we, wr_ack, fifo_ready, underrun, pix_out} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ce/we/ack/rdy/unr/pix=%b want 000000",
                     {mem_ce, mem_we, wr_ack, fifo_ready, underrun, pix_out});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%0d wdata=%h want 0/00", mem_addr, mem_wdata);
        end
        tick();
        rst_n       = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int unsigned c = 0; c < 20 && got.size() < 4; c++) begin
            tick();
            if (mem_ce && !mem_we) got.push_back(int'(mem_addr));
        end
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] != i) begin
                errors++;
                $display("FAIL reset_addr_seq[%0d]: got %0d want %0d", i,
                         (i < got.size()) ? got[i] : 32'hFFFF_FFFF, i);
            end
        end
        wait_ready(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_prefill_ready: got fifo_ready=%b want 1", fifo_ready);
        end
        extra = 0;
        repeat (6) begin tick(); if (mem_ce) extra++; end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL reset_idle_when_full: got %0d accesses want 0", extra);
        end
    endtask

    task automatic test_scanout();
        bit ok;
        logic [15:0] seq;
        seq = 16'b1010_0101_0000_1111;
        ram[0] = 8'hA5; exp_mem[0] = 8'hA5;
        ram[1] = 8'h0F; exp_mem[1] = 8'h0F;
        pulse_fs(1'b0);
        wait_ready(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_ready: got 0 want 1"); end
        for (int unsigned i = 0; i < 16; i++) begin
            pix_rd = 1'b1;
            checks++;
            if (pix_out !== seq[15 - i]) begin
                errors++;
                $display("FAIL scan_pix[%0d]: got %b want %b", i, pix_out, seq[15 - i]);
            end
            tick();
        end
        pix_rd = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL scan_underrun: got %b want 0", underrun);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int unsigned k, writes, viol;
        logic prev_ack;
        fill_random();
        pulse_fs(1'b0);
        wait_ready(30, ok);
        k = 0; writes = 0; viol = 0; prev_ack = 1'b0;
        wr_req  = 1'b1;
        wr_addr = AW'(128);
        wr_data = 8'($urandom);
        for (int unsigned cyc = 0; cyc < 800; cyc++) begin
            pix_rd = 1'b1;
            checks++;
            if (pix_out !== exp_pix(cyc)) begin
                errors++;
                $display("FAIL cont_pix[%0d]: got %b want %b", cyc, pix_out, exp_pix(cyc));
            end
            tick();
            if (wr_ack) begin
                if (prev_ack) viol++;
                exp_mem[wr_addr] = wr_data;
                writes++;
                k++;
                wr_addr = AW'(128 + (k % 128));
                wr_data = 8'($urandom);
            end
            prev_ack = wr_ack;
        end
        pix_rd = 1'b0;
        wr_req = 1'b0;
        repeat (3) tick();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL cont_underrun: got %b want 0", underrun); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL cont_ack_spacing: got %0d back-to-back acks want 0", viol); end
        checks++;
        if (writes < 300) begin errors++; $display("FAIL cont_write_rate: got %0d writes want >=300", writes); end
        for (int unsigned a = 128; a < FBW; a++) begin
            checks++;
            if (ram[a] !== exp_mem[a]) begin
                errors++;
                $display("FAIL cont_readback[%0d]: got %h want %h", a, ram[a], exp_mem[a]);
            end
        end
    endtask

    task automatic test_priority();
        int unsigned reads;
        bit acked;
        logic [7:0] d;
        d = 8'($urandom);
        reads = 0; acked = 1'b0;
        wr_req  = 1'b1;
        wr_addr = AW'(200);
        wr_data = d;
        pulse_fs(1'b0);
        for (int unsigned c = 0; c < 20 && !acked; c++) begin
            if (wr_ack) begin
                acked = 1'b1;
                checks++;
                if (!(mem_ce && mem_we && mem_addr == AW'(200) && mem_wdata == d)) begin
                    errors++;
                    $display("FAIL prio_write_bus: got ce=%b we=%b addr=%0d wd=%h want 1 1 200 %h",
                             mem_ce, mem_we, mem_addr, mem_wdata, d);
                end
                exp_mem[200] = d;
                wr_req = 1'b0;
            end else begin
                if (mem_ce && !mem_we) reads++;
                tick();
            end
        end
        checks++;
        if (!acked || reads != 2) begin
            errors++;
            $display("FAIL prio_reads_before_ack: got acked=%b reads=%0d want 1 2", acked, reads);
        end
        wr_req = 1'b0;
        tick();
    endtask

    task automatic test_wrap_flush();
        bit ok, found;
        int unsigned idx, first;
        fill_random();
        ram[FBW-1] = 8'hFF; exp_mem[FBW-1] = 8'hFF;
        ram[0]     = 8'h00; exp_mem[0]     = 8'h00;
        pulse_fs(1'b0);
        wait_ready(30, ok);
        idx = 0; found = 1'b0;
        for (int unsigned c = 0; c < 4000 && !found; c++) begin
            pix_rd = ($urandom_range(3) != 0);
            if (pix_rd) begin
                checks++;
                if (pix_out !== exp_pix(idx)) begin
                    errors++;
                    $display("FAIL wrap_pre_pix[%0d]: got %b want %b", idx, pix_out, exp_pix(idx));
                end
                idx++;
            end
            tick();
            if (mem_ce && !mem_we && mem_addr == AW'(FBW - 1)) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_last_read: got none want addr %0d", FBW - 1); end
        pulse_fs(1'b1);
        first = 32'hFFFF_FFFF;
        for (int unsigned c = 0; c < 10 && first == 32'hFFFF_FFFF; c++) begin
            if (mem_ce && !mem_we) first = int'(mem_addr);
            else tick();
        end
        checks++;
        if (first != 0) begin errors++; $display("FAIL flush_next_addr: got %0d want 0", first); end
        wait_ready(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL flush_ready: got 0 want 1"); end
        for (int unsigned i = 0; i < 2100; i++) begin
            pix_rd = 1'b0;
            while (!pix_rd) begin
                pix_rd = ($urandom_range(3) != 0);
                if (!pix_rd) tick();
            end
            checks++;
            if (pix_out !== exp_pix(i)) begin
                errors++;
                $display("FAIL flush_pix[%0d]: got %b want %b", i, pix_out, exp_pix(i));
            end
            tick();
        end
        pix_rd = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL wrap_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_underrun_oor();
        bit ok, acked;
        logic [7:0] d;
        pulse_fs(1'b0);
        pix_rd = 1'b1;
        checks++;
        if (pix_out !== 1'b0) begin errors++; $display("FAIL udr_pix_empty: got %b want 0", pix_out); end
        tick();
        pix_rd = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL udr_set: got %b want 1", underrun); end
        wait_ready(30, ok);
        checks++;
        if (!ok || underrun !== 1'b1) begin
            errors++;
            $display("FAIL udr_sticky: got ready=%b underrun=%b want 1 1", fifo_ready, underrun);
        end
        ram[FBW] = 8'h3C;
        wr_req = 1'b1; wr_addr = AW'(FBW); wr_data = 8'hC3;
        acked = 1'b0;
        for (int unsigned c = 0; c < 10 && !acked; c++) begin
            tick();
            if (wr_ack) begin
                acked = 1'b1;
                checks++;
                if (mem_ce !== 1'b0) begin errors++; $display("FAIL oor_ce: got %b want 0", mem_ce); end
            end
        end
        wr_req = 1'b0;
        checks++;
        if (!acked) begin errors++; $display("FAIL oor_ack: got no ack want ack"); end
        tick();
        checks++;
        if (ram[FBW] !== 8'h3C) begin errors++; $display("FAIL oor_nowrite: got %h want 3c", ram[FBW]); end
        d = 8'($urandom);
        wr_req = 1'b1; wr_addr = AW'(FBW - 1); wr_data = d;
        acked = 1'b0;
        for (int unsigned c = 0; c < 10 && !acked; c++) begin
            tick();
            if (wr_ack) begin
                acked = 1'b1;
                checks++;
                if (!(mem_ce && mem_we && mem_addr == AW'(FBW - 1) && mem_wdata == d)) begin
                    errors++;
                    $display("FAIL last_addr_write: got ce=%b we=%b addr=%0d wd=%h want 1 1 %0d %h",
                             mem_ce, mem_we, mem_addr, mem_wdata, FBW - 1, d);
                end
            end
        end
        wr_req = 1'b0;
        tick();
        checks++;
        if (!acked || ram[FBW-1] !== d) begin
            errors++;
            $display("FAIL last_addr_data: got %h want %h", ram[FBW-1], d);
        end
        exp_mem[FBW-1] = d;
        pulse_fs(1'b0);
        checks++;
        if (underrun !== 1'b0 || fifo_ready !== 1'b0) begin
            errors++;
            $display("FAIL udr_clear: got underrun=%b ready=%b want 0 0", underrun, fifo_ready);
        end
    endtask

    initial begin
        for (int unsigned a = 0; a < FBW; a++) begin
            ram[a]     = '0;
            exp_mem[a] = '0;
        end
        test_reset();
        test_scanout();
        test_contention();
        test_priority();
        test_wrap_flush();
        test_underrun_oor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
